// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the five-stage pipeline datapath and its hazard sequencer.
// With PIPE_PERF_EN defined, the bundle also carries the stall/flush performance counters.
interface pipe_hazard_ctrl_if
`ifdef PIPE_PERF_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    // Hazard sources observed in ID, EX and MEM
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;

    // Per-stage controls, sticky error and debug state
    logic       pc_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_d;
    logic       flush_a;
    logic       flush_b;
    logic       flush_c;
    logic       mem_err;
    logic [1:0] state;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    // No valid/ready pair here: the datapath presents hazard sources every
    // cycle, and the sequencer answers in the same cycle with the enables and
    // flushes that the next posedge applies.
    modport master (
        output id_rs, id_rt, ex_mem_read, ex_rt, br_taken, mem_req, mem_ready,
        input  pc_en, en_a, en_b, en_c, en_d, flush_a, flush_b, flush_c,
        input  mem_err, state
`ifdef PIPE_PERF_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs, id_rt, ex_mem_read, ex_rt, br_taken, mem_req, mem_ready,
        output pc_en, en_a, en_b, en_c, en_d, flush_a, flush_b, flush_c,
        output mem_err, state
`ifdef PIPE_PERF_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers (load-use, MEM branch, memory wait/timeout).
// Optional macro PIPE_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
`ifdef PIPE_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);
    localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_err;

    state_t         w_state_nxt;
    logic [WCW-1:0] w_wait_cnt_nxt;
    logic           w_mem_err_nxt;
    logic           w_hz;
    logic           w_mem_stall;

    // Load in EX writing a register that the instruction in ID reads; r0 never hazards
    assign w_hz = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                  ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = ST_WAIT;
                    w_wait_cnt_nxt = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (!bus.mem_ready) begin
                    // The count includes the RUN cycle that first saw the miss
                    if (TMO_EN && (r_wait_cnt == TMO)) begin
                        w_state_nxt   = ST_ERR;
                        w_mem_err_nxt = 1'b1;
                    end else if (r_wait_cnt != '1) begin
                        w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
                    end
                end else begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.pc_en   = 1'b1;
        bus.en_a    = 1'b1;
        bus.en_b    = 1'b1;
        bus.en_c    = 1'b1;
        bus.en_d    = 1'b1;
        bus.flush_a = 1'b0;
        bus.flush_b = 1'b0;
        bus.flush_c = 1'b0;
        if (rst) begin
            {bus.pc_en, bus.en_a, bus.en_b, bus.en_c, bus.en_d} = 5'b00000;
            {bus.flush_a, bus.flush_b, bus.flush_c}             = 3'b111;
        end else if ((r_state == ST_ERR) ||
                     ((r_state == ST_RUN) && w_mem_stall) ||
                     ((r_state == ST_WAIT) && !bus.mem_ready)) begin
            {bus.pc_en, bus.en_a, bus.en_b, bus.en_c, bus.en_d} = 5'b00000;
        end else if (bus.br_taken) begin
            // Squash the three younger instructions; PC loads the branch target
            {bus.flush_a, bus.flush_b, bus.flush_c} = 3'b111;
        end else if (w_hz) begin
            bus.pc_en   = 1'b0;
            bus.en_a    = 1'b0;
            bus.flush_b = 1'b1;
        end
    end

    assign bus.mem_err = r_mem_err;
    assign bus.state   = r_state;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!bus.pc_en && (r_state != ST_ERR) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (bus.flush_a && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4; control outputs packed as
// {pc_en,en_a,en_b,en_c,en_d,flush_a,flush_b,flush_c}.
module tb_pipe_hazard_ctrl;
    localparam logic [7:0] C_RUN   = 8'hF8;
    localparam logic [7:0] C_STALL = 8'h00;
    localparam logic [7:0] C_RST   = 8'h07;
    localparam logic [7:0] C_BR    = 8'hFF;
    localparam logic [7:0] C_HZ    = 8'h3A;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

`ifdef PIPE_PERF_EN
    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
    logic [31:0] snap_stall;
    logic [31:0] snap_flush;
`else
    pipe_hazard_ctrl_if bus ();
`endif

`ifdef PIPE_PERF_EN
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ctrl;
    assign ctrl = {bus.pc_en, bus.en_a, bus.en_b, bus.en_c, bus.en_d,
                   bus.flush_a, bus.flush_b, bus.flush_c};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change just after negedge, outputs sampled 1ns later
    task automatic drive(input logic mrd, input logic [4:0] rt_ex, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req, input logic rdy);
        bus.ex_mem_read = mrd;
        bus.ex_rt       = rt_ex;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.br_taken    = br;
        bus.mem_req     = req;
        bus.mem_ready   = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp_ctrl,
                       input logic [1:0] exp_state, input logic exp_err);
        #1;
        check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        check({tag, ".state"}, 32'(bus.state), 32'(exp_state));
        check({tag, ".err"}, 32'(bus.mem_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        cyc("reset_a", C_RST, 2'd0, 1'b0);
        cyc("reset_b", C_RST, 2'd0, 1'b0);
`ifdef PIPE_PERF_EN
        check("perf_rst_stall", bus.stall_cycles, 32'd0);
        check("perf_rst_flush", bus.flush_events, 32'd0);
`endif
        rst = 1'b0;
        cyc("idle", C_RUN, 2'd0, 1'b0);

`ifdef PIPE_PERF_EN
        snap_stall = bus.stall_cycles;
        snap_flush = bus.flush_events;
`endif
        // Load-use on rs: one bubble, then the load has moved on
        drive(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
        cyc("hz_rs", C_HZ, 2'd0, 1'b0);
        idle();
        cyc("hz_clear", C_RUN, 2'd0, 1'b0);
        drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
        cyc("hz_rt", C_HZ, 2'd0, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("hz_r0", C_RUN, 2'd0, 1'b0);
        drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0);
        cyc("hz_noload", C_RUN, 2'd0, 1'b0);

        // Branch wins over a simultaneous hazard
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("br_hz", C_BR, 2'd0, 1'b0);
        idle();
        cyc("br_after", C_RUN, 2'd0, 1'b0);

        // Three-cycle memory wait, resume without events; hazard during wait ignored
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mw_p0", C_STALL, 2'd0, 1'b0);
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mw_p1", C_STALL, 2'd1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("mw_p2", C_STALL, 2'd1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("mw_plain_resume", C_RUN, 2'd1, 1'b0);
        idle();
        cyc("mw_plain_after", C_RUN, 2'd0, 1'b0);
`ifdef PIPE_PERF_EN
        // Two hazard bubbles, three wait stalls, one branch flush
        check("perf_stall_delta", bus.stall_cycles - snap_stall, 32'd5);
        check("perf_flush_delta", bus.flush_events - snap_flush, 32'd1);
`endif

        // Three-cycle wait, resume with a branch held in EX/MEM
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mwb_0", C_STALL, 2'd0, 1'b0);
        cyc("mwb_1", C_STALL, 2'd1, 1'b0);
        cyc("mwb_2", C_STALL, 2'd1, 1'b0);
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc("mwb_resume", C_BR, 2'd1, 1'b0);
        idle();
        cyc("mwb_after", C_RUN, 2'd0, 1'b0);

        // Resume with a pending load-use hazard
        drive(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b0);
        cyc("mwh_0", C_STALL, 2'd0, 1'b0);
        drive(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1);
        cyc("mwh_resume", C_HZ, 2'd1, 1'b0);
        idle();
        cyc("mwh_after", C_RUN, 2'd0, 1'b0);

        // mem_ready alone, and a single-cycle hit, never stall
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("rdy_noreq", C_RUN, 2'd0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        cyc("req_hit", C_RUN, 2'd0, 1'b0);

        // Reset in the middle of a wait
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("mwr_0", C_STALL, 2'd0, 1'b0);
        cyc("mwr_1", C_STALL, 2'd1, 1'b0);
        rst = 1'b1;
        cyc("mwr_rst", C_RST, 2'd1, 1'b0);
        rst = 1'b0;
        idle();
        cyc("mwr_after", C_RUN, 2'd0, 1'b0);

        // Timeout: RUN miss cycle + four MEM_WAIT cycles, then sticky ERR
`ifdef PIPE_PERF_EN
        snap_stall = bus.stall_cycles;
`endif
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("to_0", C_STALL, 2'd0, 1'b0);
        cyc("to_1", C_STALL, 2'd1, 1'b0);
        cyc("to_2", C_STALL, 2'd1, 1'b0);
        cyc("to_3", C_STALL, 2'd1, 1'b0);
        cyc("to_4", C_STALL, 2'd1, 1'b0);
        cyc("to_err", C_STALL, 2'd2, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc("to_err_rdy", C_STALL, 2'd2, 1'b1);
        idle();
        cyc("to_err_idle", C_STALL, 2'd2, 1'b1);
`ifdef PIPE_PERF_EN
        check("perf_err_stall", bus.stall_cycles - snap_stall, 32'd5);
`endif
        rst = 1'b1;
        cyc("to_rst", C_RST, 2'd2, 1'b1);
        rst = 1'b0;
        cyc("to_after", C_RUN, 2'd0, 1'b0);
`ifdef PIPE_PERF_EN
        check("perf_clr_stall", bus.stall_cycles, 32'd0);
        check("perf_clr_flush", bus.flush_events, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
